alu_core: RTL and testbench
===========================

# alu_core

Responder side of the CPU's ALU special-register interface. Accepts operand writes and operation launches from the CPU destination path. Buffers completed results in a small FIFO that the CPU source path reads combinationally within the same cycle. Single-cycle ops complete in one clock; unsigned multiply runs as a 32-step iterative shift-add.

## Interface
- `DEPTH`, default 4: result FIFO entries; power of two, ≥2.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_input_op` in 2: input op. 0 = OPA, 1 = OPB, 2 = OPC, 3 = CLR.
- `i_data_valid` in 1: qualifies `i_input_op`/`i_data` this cycle.
- `i_data` in 32: operand or opcode payload.
- `i_output_op` in 2: read select. 0 = LO, 1 = HI, 2 = FLAGS, 3 = STATUS.
- `i_result_empty` in 1: read strobe; pops the FIFO only when `i_output_op` = LO.
- `o_result_valid` out 1: FIFO non-empty.
- `o_result` out 32: selected field of head entry, or status word.
- `o_result_flags` out 5: flags of head entry; 0 when empty.

## Operation
- **OPA/OPB:** load A/B from `i_data`. Always accepted, including while BUSY; the multiplier uses private copies captured at launch.
- **OPC:** `i_data[3:0]` is the opcode. Launch is accepted iff the state is IDLE and pre-edge count < DEPTH. A same-cycle pop does not free a slot for this check. A rejected launch sets sticky `lost`.
- **Opcodes** (shift amount is `B[4:0]`):
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR: single-cycle.
  - 8 MULU: 64-bit unsigned product, multi-cycle.
  - 9–15: invalid. Push result 0 with flag E.
- **Flags:** bit0 Z, bit1 N, bit2 C, bit3 V, bit4 E.
  - ADD: C = carry-out; V = signed overflow.
  - SUB: C = borrow (A < B unsigned); V = signed overflow.
  - Logic ops: C = V = 0.
  - Shifts: C = last bit shifted out (0 when amount is 0); V = 0.
  - MULU: Z = 64-bit product is zero; N = bit 63; C = HI ≠ 0; V = 0.
  - Z and N come from the LO word, except for MULU.
- **Entry fields:** LO, HI, flags. HI = 0 for every op except MULU.
- **FSM:**
  - IDLE → BUSY on MULU launch; step counter = 0; multiplicand/multiplier captured.
  - BUSY: one shift-add step per cycle. Step 31 pushes the entry and returns to IDLE.
  - MULU does not reserve its slot. If the FIFO is full at completion, the entry is dropped and `lost` is set.
- **CLR:**
  - Flushes the FIFO, aborts BUSY → IDLE, clears `lost`. A and B are kept.
  - Takes priority over a same-cycle pop, push, or completion.
- **Reads:**
  - LO/HI/FLAGS return the head entry's field, or 0 when empty.
  - STATUS = {27'b0, count[2:0], lost, busy}. Count saturates the field display at 7.
  - Pop on an empty FIFO is ignored.
- **Simultaneous push and pop:** count unchanged; data ordering preserved.

## Timing
- **Reset values:** FIFO empty, IDLE, A = B = 0, `lost` = 0. Outputs read `o_result_valid` = 0, `o_result` = 0 for LO/HI/FLAGS (STATUS = 0), `o_result_flags` = 0.
- **Outputs:** all are combinational from registered state plus `i_output_op`; no path from `i_data`/`i_input_op` to outputs.
- **Single-cycle op:** OPC sampled at edge N; entry visible during cycle N+1.
- **MULU:** launched at edge N; entry visible in cycle N+33; `busy` reads 1 during cycles N+1..N+32.
- **Pop:** takes effect at the edge; the next head is visible the following cycle.
- **Reset mid-multiply:** immediate return to IDLE; nothing is pushed.

## Structure
- `alu_core_pkg` holds:
  - input/output op encodings;
  - opcode constants;
  - flag bit indices;
  - STATUS field positions;
  - FSM state encoding.
- Sub-module `alu_result_fifo`: parameterised DEPTH; 69-bit entries; combinational head; count output; synchronous flush.

## Test plan
- Reset, then A = 0xFFFFFFFF, B = 1, ADD, read FLAGS then LO → flags = 0b00101 (Z, C), LO = 0; count returns to 0.
- A = 0x80000000, B = 4, SAR → LO = 0xF8000000, N = 1, C = 0. Opcode 12 → LO = 0, E = 1.
- A = 0xFFFFFFFF, B = 0xFFFFFFFF, MULU → `busy` for 32 cycles; entry in cycle N+33; HI = 0xFFFFFFFE, LO = 0x00000001, C = 1.
- Four ADDs with DEPTH = 4, then a fifth ADD alongside a LO pop → fifth rejected, `lost` = 1, count = 3; results returned in launch order.
- OPC during BUSY → rejected, `lost` set. CLR mid-MULU → IDLE, count 0, `lost` 0. Asserting `i_rst` mid-MULU → no entry ever appears.

Source files
------------

// File: rtl/alu_core_pkg.sv
// Shared encodings for the ALU special-register responder: op selects, opcodes,
// flag/status bit positions, FSM state and the result FIFO entry layout.
package alu_core_pkg;

    typedef enum logic [1:0] {
        IN_OPA = 2'd0,
        IN_OPB = 2'd1,
        IN_OPC = 2'd2,
        IN_CLR = 2'd3
    } in_op_e;

    typedef enum logic [1:0] {
        OUT_LO     = 2'd0,
        OUT_HI     = 2'd1,
        OUT_FLAGS  = 2'd2,
        OUT_STATUS = 2'd3
    } out_op_e;

    localparam logic [3:0] OPC_ADD  = 4'd0;
    localparam logic [3:0] OPC_SUB  = 4'd1;
    localparam logic [3:0] OPC_AND  = 4'd2;
    localparam logic [3:0] OPC_OR   = 4'd3;
    localparam logic [3:0] OPC_XOR  = 4'd4;
    localparam logic [3:0] OPC_SHL  = 4'd5;
    localparam logic [3:0] OPC_SHR  = 4'd6;
    localparam logic [3:0] OPC_SAR  = 4'd7;
    localparam logic [3:0] OPC_MULU = 4'd8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_E = 4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_LOST    = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_CNT_W   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // 69-bit FIFO entry
    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] hi;
        logic [31:0] lo;
    } entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO with a combinational head; flush wins over push and pop.
module alu_result_fifo
    import alu_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_core.sv
// ALU special-register responder: operand/launch decode, single-cycle ALU,
// 32-step shift-add unsigned multiplier and result FIFO read mux.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_input_op,
    input  logic        i_data_valid,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_output_op,
    input  logic        i_result_empty,
    output logic        o_result_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_result_flags
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   a, b, mcand;
    logic [63:0]   prod, prod_next;
    logic [32:0]   mul_sum, sum33, dif33;
    logic [4:0]    step, sh;
    state_e        state;
    logic          lost;
    logic [CW-1:0] count;
    logic [2:0]    cnt_disp;
    entry_t        head, alu_entry, mul_entry, push_entry;
    logic [31:0]   alu_lo;
    logic          alu_c, alu_v, alu_err;
    logic          clr, opc, launch, launch_mul, mul_done, full, push, pop;

    assign clr        = i_data_valid && (i_input_op == IN_CLR);
    assign opc        = i_data_valid && (i_input_op == IN_OPC);
    assign full       = (count == CW'(DEPTH));
    assign launch     = opc && (state == ST_IDLE) && !full;
    assign launch_mul = launch && (i_data[3:0] == OPC_MULU);
    assign mul_done   = (state == ST_BUSY) && (step == 5'd31);

    assign sh    = b[4:0];
    assign sum33 = {1'b0, a} + {1'b0, b};
    assign dif33 = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_lo  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (i_data[3:0])
            OPC_ADD: begin
                alu_lo = sum33[31:0];
                alu_c  = sum33[32];
                alu_v  = (a[31] == b[31]) && (sum33[31] != a[31]);
            end
            OPC_SUB: begin
                alu_lo = dif33[31:0];
                alu_c  = dif33[32];
                alu_v  = (a[31] != b[31]) && (dif33[31] != a[31]);
            end
            OPC_AND: alu_lo = a & b;
            OPC_OR:  alu_lo = a | b;
            OPC_XOR: alu_lo = a ^ b;
            OPC_SHL: begin
                alu_lo = a << sh;
                alu_c  = (sh != 5'd0) && a[5'(6'd32 - {1'b0, sh})];
            end
            OPC_SHR: begin
                alu_lo = a >> sh;
                alu_c  = (sh != 5'd0) && a[sh - 5'd1];
            end
            OPC_SAR: begin
                alu_lo = 32'($signed(a) >>> sh);
                alu_c  = (sh != 5'd0) && a[sh - 5'd1];
            end
            OPC_MULU: alu_lo = '0;
            default:  alu_err = 1'b1;
        endcase

        alu_entry.lo    = alu_lo;
        alu_entry.hi    = '0;
        alu_entry.flags = '0;
        if (alu_err) begin
            alu_entry.flags[FLAG_E] = 1'b1;
        end else begin
            alu_entry.flags[FLAG_Z] = (alu_lo == 32'd0);
            alu_entry.flags[FLAG_N] = alu_lo[31];
            alu_entry.flags[FLAG_C] = alu_c;
            alu_entry.flags[FLAG_V] = alu_v;
        end
    end

    // Low half of prod holds the remaining multiplier bits; high half accumulates.
    assign mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    assign prod_next = {mul_sum, prod[31:1]};

    always_comb begin
        mul_entry.lo            = prod_next[31:0];
        mul_entry.hi            = prod_next[63:32];
        mul_entry.flags         = '0;
        mul_entry.flags[FLAG_Z] = (prod_next == 64'd0);
        mul_entry.flags[FLAG_N] = prod_next[63];
        mul_entry.flags[FLAG_C] = (prod_next[63:32] != 32'd0);
    end

    assign push_entry = mul_done ? mul_entry : alu_entry;
    assign push       = !clr && ((launch && !launch_mul) || (mul_done && !full));
    assign pop        = !clr && i_result_empty && (i_output_op == OUT_LO);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            step  <= '0;
            a     <= '0;
            b     <= '0;
            mcand <= '0;
            prod  <= '0;
            lost  <= 1'b0;
        end else begin
            if (i_data_valid && (i_input_op == IN_OPA)) a <= i_data;
            if (i_data_valid && (i_input_op == IN_OPB)) b <= i_data;
            if (clr) begin
                state <= ST_IDLE;
                lost  <= 1'b0;
            end else begin
                if ((opc && !launch) || (mul_done && full)) lost <= 1'b1;
                case (state)
                    ST_IDLE: if (launch_mul) begin
                        state <= ST_BUSY;
                        step  <= '0;
                        mcand <= a;
                        prod  <= {32'd0, b};
                    end
                    ST_BUSY: begin
                        prod <= prod_next;
                        step <= step + 5'd1;
                        if (mul_done) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .flush     (clr),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign o_result_valid = (count != '0);
    assign cnt_disp       = (32'(count) > 32'd7) ? 3'd7 : 3'(count);
    assign o_result_flags = o_result_valid ? head.flags : 5'd0;

    always_comb begin
        o_result = '0;
        case (i_output_op)
            OUT_LO:    if (o_result_valid) o_result = head.lo;
            OUT_HI:    if (o_result_valid) o_result = head.hi;
            OUT_FLAGS: if (o_result_valid) o_result = {27'd0, head.flags};
            default: begin
                o_result[STAT_BUSY]                   = (state == ST_BUSY);
                o_result[STAT_LOST]                   = lost;
                o_result[STAT_CNT_LSB +: STAT_CNT_W]  = cnt_disp;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table, multiply timing,
// FIFO overflow/ordering, CLR and reset aborts, then randomized ops vs a model.
module tb_alu_core;
    import alu_core_pkg::*;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_input_op;
    logic        i_data_valid;
    logic [31:0] i_data;
    logic [1:0]  i_output_op;
    logic        i_result_empty;
    logic        o_result_valid;
    logic [31:0] o_result;
    logic [4:0]  o_result_flags;

    int checks   = 0;
    int failures = 0;

    alu_core #(.DEPTH(DEPTH)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_input_op     (i_input_op),
        .i_data_valid   (i_data_valid),
        .i_data         (i_data),
        .i_output_op    (i_output_op),
        .i_result_empty (i_result_empty),
        .o_result_valid (o_result_valid),
        .o_result       (o_result),
        .o_result_flags (o_result_flags)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  flags;
        logic [4:0]  fmask;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain wide/signed arithmetic, returns {flags, hi, lo}.
    function automatic logic [68:0] ref_alu(input logic [3:0] opc, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, sr;
        logic [63:0] w;
        logic [31:0] lo, hi;
        logic        c, v;
        logic [4:0]  f;
        int          sh;
        sh = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lo = 0; hi = 0; c = 0; v = 0; w = 0; sr = 0;
        case (opc)
            4'd0: begin w = 64'(a) + 64'(b); lo = w[31:0]; c = w[32]; sr = sa + sb; end
            4'd1: begin lo = a - b; c = (a < b); sr = sa - sb; end
            4'd2: lo = a & b;
            4'd3: lo = a | b;
            4'd4: lo = a ^ b;
            4'd5: begin w = 64'(a) << sh; lo = w[31:0]; c = w[32]; end
            4'd6: begin lo = a >> sh; c = (sh > 0) ? a[sh-1] : 1'b0; end
            4'd7: begin lo = 32'(sa >>> sh); c = (sh > 0) ? a[sh-1] : 1'b0; end
            4'd8: begin w = 64'(a) * 64'(b); lo = w[31:0]; hi = w[63:32]; end
            default: ;
        endcase
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (opc > 4'd8)       f = 5'b10000;
        else if (opc == 4'd8) f = {2'b00, hi != 0, w[63], w == 0};
        else                  f = {1'b0, v, c, lo[31], lo == 0};
        return {f, hi, lo};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic put(input logic [1:0] op, input logic [31:0] d);
        i_data_valid = 1'b1;
        i_input_op   = op;
        i_data       = d;
        tick();
        i_data_valid = 1'b0;
    endtask

    task automatic peek(input logic [1:0] op, output logic [31:0] r);
        i_output_op = op;
        #1;
        r = o_result;
    endtask

    task automatic pop_lo();
        i_output_op    = OUT_LO;
        i_result_empty = 1'b1;
        tick();
        i_result_empty = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] r;
        peek(OUT_STATUS, r);
        check(name, r, exp);
    endtask

    task automatic check_head(input string name, input logic [68:0] exp, input logic [4:0] fmask);
        logic [31:0] r;
        peek(OUT_FLAGS, r);
        check({name, ".flags"}, r & 32'(fmask), 32'(exp[68:64] & fmask));
        check({name, ".flagport"}, o_result_flags & fmask, exp[68:64] & fmask);
        peek(OUT_HI, r);
        check({name, ".hi"}, r, exp[63:32]);
        peek(OUT_LO, r);
        check({name, ".lo"}, r, exp[31:0]);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (o_result_valid) ok = 1'b1;
            else tick();
        end
        if (o_result_valid) ok = 1'b1;
    endtask

    task automatic run_op(input string name, input logic [3:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [68:0] exp, input logic [4:0] fmask);
        bit ok;
        put(IN_OPA, a);
        put(IN_OPB, b);
        put(IN_OPC, {28'd0, opc});
        wait_valid(40, ok);
        check({name, ".ready"}, ok, 1);
        check_head(name, exp, fmask);
        pop_lo();
        check_status({name, ".drained"}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, ra, rb;
        logic [68:0] exp_q[$];
        logic [68:0] e;
        logic [3:0]  opc;
        bit          seen;

        i_rst = 1'b1; i_input_op = 2'd0; i_data_valid = 1'b0; i_data = '0;
        i_output_op = 2'd0; i_result_empty = 1'b0;

        vecs.push_back('{"add_wrap", 4'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'h05, 5'h1F});
        vecs.push_back('{"sar",      4'd7, 32'h80000000, 32'h4, 32'hF8000000, 32'h0, 5'h02, 5'h1F});
        vecs.push_back('{"invalid",  4'd12, 32'h1234, 32'h5678, 32'h0, 32'h0, 5'h10, 5'h10});
        vecs.push_back('{"sub_brw",  4'd1, 32'h5, 32'h7, 32'hFFFFFFFE, 32'h0, 5'h06, 5'h1F});
        vecs.push_back('{"add_ovf",  4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 5'h0A, 5'h1F});
        vecs.push_back('{"sub_ovf",  4'd1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h0, 5'h08, 5'h1F});
        vecs.push_back('{"and",      4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h0, 5'h01, 5'h1F});
        vecs.push_back('{"or",       4'd3, 32'h80000000, 32'h1, 32'h80000001, 32'h0, 5'h02, 5'h1F});
        vecs.push_back('{"xor",      4'd4, 32'hAAAA5555, 32'hAAAA5555, 32'h0, 32'h0, 5'h01, 5'h1F});
        vecs.push_back('{"shl1",     4'd5, 32'h80000001, 32'h1, 32'h2, 32'h0, 5'h04, 5'h1F});
        vecs.push_back('{"shl0",     4'd5, 32'h80000000, 32'h20, 32'h80000000, 32'h0, 5'h02, 5'h1F});
        vecs.push_back('{"shr1",     4'd6, 32'h3, 32'h1, 32'h1, 32'h0, 5'h04, 5'h1F});
        vecs.push_back('{"shr31",    4'd6, 32'h80000000, 32'd31, 32'h1, 32'h0, 5'h00, 5'h1F});
        vecs.push_back('{"mulu_max", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 5'h06, 5'h1F});

        // Reset state
        tick(); tick();
        i_rst = 1'b0;
        tick();
        check("rst.valid", o_result_valid, 0);
        check("rst.flags", o_result_flags, 0);
        for (int k = 0; k < 4; k++) begin
            peek(2'(k), r);
            check($sformatf("rst.out%0d", k), r, 0);
        end

        // A and B reset to zero
        put(IN_OPC, {28'd0, OPC_ADD});
        check_head("rst_ab", {5'h01, 64'd0}, 5'h1F);
        pop_lo();

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].opc, vecs[i].a, vecs[i].b,
                   {vecs[i].flags, vecs[i].hi, vecs[i].lo}, vecs[i].fmask);

        // Multiply timing; operand writes during BUSY must not disturb it
        put(IN_OPA, 32'hFFFFFFFF);
        put(IN_OPB, 32'hFFFFFFFF);
        put(IN_OPC, {28'd0, OPC_MULU});
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            peek(OUT_STATUS, r);
            if (r !== 32'h1 || o_result_valid) seen = 1'b1;
            if (i == 2)      put(IN_OPA, 32'h0);
            else if (i == 3) put(IN_OPB, 32'h0);
            else             tick();
        end
        check("mul.busy_window", seen, 0);
        check("mul.valid_n33", o_result_valid, 1);
        check_status("mul.status_done", 32'h4);
        check_head("mul.entry", {5'h06, 32'hFFFFFFFE, 32'h1}, 5'h1F);
        pop_lo();

        // Fill FIFO, then a rejected fifth launch alongside a pop
        for (int k = 0; k < DEPTH; k++) begin
            ra = $urandom; rb = $urandom;
            put(IN_OPA, ra);
            put(IN_OPB, rb);
            put(IN_OPC, {28'd0, OPC_ADD});
            exp_q.push_back(ref_alu(OPC_ADD, ra, rb));
        end
        check_status("full.status", 32'h10);
        peek(OUT_LO, r);
        check("full.head_lo", r, exp_q[0][31:0]);
        i_data_valid = 1'b1; i_input_op = IN_OPC; i_data = 32'd0;
        i_output_op = OUT_LO; i_result_empty = 1'b1;
        tick();
        i_data_valid = 1'b0; i_result_empty = 1'b0;
        void'(exp_q.pop_front());
        check_status("full.lost_cnt3", 32'hE);
        for (int k = 0; k < DEPTH - 1; k++) begin
            e = exp_q.pop_front();
            check_head($sformatf("order%0d", k), e, 5'h1F);
            pop_lo();
        end
        check_status("order.empty_lost", 32'h2);

        // Launch during BUSY is rejected; CLR aborts multiply
        put(IN_CLR, 32'd0);
        check_status("clr.status", 32'h0);
        ra = $urandom; rb = $urandom;
        put(IN_OPA, ra);
        put(IN_OPB, rb);
        put(IN_OPC, {28'd0, OPC_MULU});
        tick();
        put(IN_OPC, {28'd0, OPC_ADD});
        check_status("busy_opc.lost", 32'h3);
        tick(); tick();
        put(IN_CLR, 32'd0);
        check_status("clr_mid.status", 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_result_valid) seen = 1'b1;
            tick();
        end
        check("clr_mid.no_entry", seen, 0);
        run_op("clr_keeps_ab", OPC_ADD, ra, rb, ref_alu(OPC_ADD, ra, rb), 5'h1F);

        // Reset mid-multiply
        put(IN_OPA, 32'd3);
        put(IN_OPB, 32'd5);
        put(IN_OPC, {28'd0, OPC_MULU});
        for (int i = 0; i < 10; i++) tick();
        i_rst = 1'b1;
        check_status("rst_mid.async", 32'h0);
        tick();
        i_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_result_valid) seen = 1'b1;
            tick();
        end
        check("rst_mid.no_entry", seen, 0);
        check_status("rst_mid.status", 32'h0);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            opc = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (n % 7 == 0) ra = 32'h80000000 | ra;
            run_op($sformatf("rnd%0d_op%0d", n, opc), opc, ra, rb, ref_alu(opc, ra, rb), 5'h1F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
